// File: rtl/byte_decryptor.sv
// byte_decryptor: iterative receive-side cipher. Accepts one ciphertext byte and key,
// undoes ROUNDS rounds at one round per clock, then presents the plaintext byte.
module byte_decryptor #(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t     state;
  logic [7:0] data_q;
  logic [7:0] key_q;
  logic [3:0] round_q;
  logic [7:0] round_out;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction

  // Inverse of x = rotl1(rev(x) ^ K_r): rotate right, strip the round key, un-reverse.
  function automatic logic [7:0] undo_round(input logic [7:0] x,
                                            input logic [7:0] key,
                                            input logic [3:0] r);
    logic [15:0] dbl;
    logic [7:0]  kr;
    dbl = {key, key} << r[2:0];
    kr  = dbl[15:8] ^ {4'b0000, r};
    return rev8({x[0], x[7:1]} ^ kr);
  endfunction

  assign round_out = undo_round(data_q, key_q, round_q);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= 8'h00;
      key_q    <= 8'h00;
      round_q  <= 4'd0;
      out_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            key_q   <= in_key;
            round_q <= LAST_ROUND;
            state   <= ROUND;
          end
        end
        ROUND: begin
          data_q <= round_out;
          if (round_q == 4'd0) begin
            out_data <= round_out;
            state    <= DONE;
          end else begin
            round_q <= round_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
